lif_neuron: RTL and testbench

LIF_NEURON -- requirements
Module: lif_neuron

---
 rtl/lif_neuron_if.sv | 24 ++
 rtl/lif_neuron.sv | 101 ++++++++++
 tb/tb_lif_neuron.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/lif_neuron_if.sv
// Signal bundle between a leaky integrate-and-fire neuron and whatever drives it.
// The master supplies current, threshold and reset potential; the neuron returns its state.
interface lif_neuron_if #(
  parameter int WIDTH = 18
);
  logic                    en;
  logic signed [WIDTH-1:0] i_in;
  logic signed [WIDTH-1:0] threshold;
  logic signed [WIDTH-1:0] v_reset;
  logic                    spike;
  logic signed [WIDTH-1:0] v_out;
  logic                    refractory;
  logic [15:0]             spike_count;

  modport master (
    output en, i_in, threshold, v_reset,
    input  spike, v_out, refractory, spike_count
  );

  modport slave (
    input  en, i_in, threshold, v_reset,
    output spike, v_out, refractory, spike_count
  );
endinterface

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: saturating leaky integrator, one-cycle spike,
// fixed-length refractory period and a saturating spike counter.
module lif_neuron #(
  parameter int WIDTH          = 18,
  parameter int LEAK_SHIFT     = 4,
  parameter int REFRACT_CYCLES = 8
) (
  input logic         clock,
  input logic         reset,
  lif_neuron_if.slave nif
);

  localparam int CNT_W = (REFRACT_CYCLES > 0) ? $clog2(REFRACT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD =
    CNT_W'((REFRACT_CYCLES > 0) ? REFRACT_CYCLES - 1 : 0);
  localparam logic signed [WIDTH+1:0] V_MAX = {3'b000, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH+1:0] V_MIN = {3'b111, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    INTEGRATE  = 2'd0,
    FIRE       = 2'd1,
    REFRACTORY = 2'd2
  } state_t;

  state_t                  state_p0, state_nxt;
  logic signed [WIDTH-1:0] v_p0, v_nxt;
  logic [CNT_W-1:0]        cnt_p0, cnt_nxt;
  logic [15:0]             count_p0, count_nxt;

  logic signed [WIDTH+1:0] v_ext;
  logic signed [WIDTH+1:0] i_ext;
  logic signed [WIDTH+1:0] v_sum;
  logic signed [WIDTH-1:0] v_sat;

  function automatic logic signed [WIDTH-1:0] saturate(input logic signed [WIDTH+1:0] x);
    if (x > V_MAX)      return V_MAX[WIDTH-1:0];
    else if (x < V_MIN) return V_MIN[WIDTH-1:0];
    else                return x[WIDTH-1:0];
  endfunction

  // Two guard bits hold the worst case of v - leak + i before clamping.
  assign v_ext = {{2{v_p0[WIDTH-1]}}, v_p0};
  assign i_ext = {{2{nif.i_in[WIDTH-1]}}, nif.i_in};
  assign v_sum = v_ext - (v_ext >>> LEAK_SHIFT) + i_ext;
  assign v_sat = saturate(v_sum);

  always_comb begin
    state_nxt = state_p0;
    v_nxt     = v_p0;
    cnt_nxt   = cnt_p0;
    count_nxt = count_p0;
    case (state_p0)
      INTEGRATE: begin
        if (nif.en) begin
          if (v_sat >= nif.threshold) begin
            state_nxt = FIRE;
            v_nxt     = nif.v_reset;
            if (count_p0 != 16'hFFFF) count_nxt = count_p0 + 16'd1;
          end else begin
            v_nxt = v_sat;
          end
        end
      end
      FIRE: begin
        if (REFRACT_CYCLES > 0) begin
          state_nxt = REFRACTORY;
          cnt_nxt   = CNT_LOAD;
        end else begin
          state_nxt = INTEGRATE;
        end
      end
      REFRACTORY: begin
        // Counter is loaded with N-1 so the state lasts exactly N cycles.
        if (cnt_p0 == '0) state_nxt = INTEGRATE;
        else              cnt_nxt   = cnt_p0 - CNT_W'(1);
      end
      default: state_nxt = INTEGRATE;
    endcase
  end

  // ---- state register ----
  always_ff @(posedge clock) begin
    if (reset) begin
      state_p0 <= INTEGRATE;
      v_p0     <= '0;
      cnt_p0   <= '0;
      count_p0 <= '0;
    end else begin
      state_p0 <= state_nxt;
      v_p0     <= v_nxt;
      cnt_p0   <= cnt_nxt;
      count_p0 <= count_nxt;
    end
  end

  assign nif.spike       = (state_p0 == FIRE);
  assign nif.refractory  = (state_p0 == REFRACTORY);
  assign nif.v_out       = v_p0;
  assign nif.spike_count = count_p0;

endmodule

// File: tb/tb_lif_neuron.sv
// Bench for lif_neuron: two builds (8-cycle and zero refractory) driven in lockstep
// and compared each cycle against a behavioural neuron model plus directed scenarios.
module tb_lif_neuron;
  localparam int W  = 18;
  localparam int LS = 4;

  logic   clock = 1'b0;
  logic   reset;
  logic   en;
  longint i_in, thr, vr;

  always #5 clock = ~clock;

  lif_neuron_if #(.WIDTH(W)) nif_a ();
  lif_neuron_if #(.WIDTH(W)) nif_b ();

  assign nif_a.en = en;
  assign nif_a.i_in = i_in[W-1:0];
  assign nif_a.threshold = thr[W-1:0];
  assign nif_a.v_reset = vr[W-1:0];
  assign nif_b.en = en;
  assign nif_b.i_in = i_in[W-1:0];
  assign nif_b.threshold = thr[W-1:0];
  assign nif_b.v_reset = vr[W-1:0];

  lif_neuron #(.WIDTH(W), .LEAK_SHIFT(LS), .REFRACT_CYCLES(8)) dut_a (
    .clock(clock), .reset(reset), .nif(nif_a));
  lif_neuron #(.WIDTH(W), .LEAK_SHIFT(LS), .REFRACT_CYCLES(0)) dut_b (
    .clock(clock), .reset(reset), .nif(nif_b));

  int n_cmp = 0;
  int n_bad = 0;

  // Model: potential, number of remaining non-integrating cycles after a spike, spike total.
  longint mv[2];
  int     busy[2];
  int     scnt[2];

  function automatic int refract_of(input int k);
    return (k == 0) ? 8 : 0;
  endfunction

  function automatic longint floor_div(input longint a, input longint d);
    longint q;
    q = a / d;
    if ((a % d != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic longint rnd(input longint lo, input longint hi);
    return lo + longint'($urandom_range(0, int'(hi - lo)));
  endfunction

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    longint vn;
    longint vmax, vmin;
    vmax = (longint'(1) <<< (W - 1)) - 1;
    vmin = -(longint'(1) <<< (W - 1));
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        mv[k] = 0; busy[k] = 0; scnt[k] = 0;
      end else if (busy[k] > 0) begin
        busy[k]--;
      end else if (en) begin
        vn = mv[k] - floor_div(mv[k], longint'(1) <<< LS) + i_in;
        if (vn > vmax) vn = vmax;
        if (vn < vmin) vn = vmin;
        if (vn >= thr) begin
          mv[k]   = vr;
          busy[k] = refract_of(k) + 1;
          if (scnt[k] < 65535) scnt[k]++;
        end else begin
          mv[k] = vn;
        end
      end
    end
  endtask

  task automatic compare_all();
    int r;
    r = refract_of(0);
    check("a.spike", longint'(nif_a.spike), longint'(busy[0] == r + 1));
    check("a.refractory", longint'(nif_a.refractory), longint'(busy[0] > 0 && busy[0] <= r));
    check("a.v_out", longint'(nif_a.v_out), mv[0]);
    check("a.spike_count", longint'(nif_a.spike_count), longint'(scnt[0]));
    r = refract_of(1);
    check("b.spike", longint'(nif_b.spike), longint'(busy[1] == r + 1));
    check("b.refractory", longint'(nif_b.refractory), longint'(busy[1] > 0 && busy[1] <= r));
    check("b.v_out", longint'(nif_b.v_out), mv[1]);
    check("b.spike_count", longint'(nif_b.spike_count), longint'(scnt[1]));
  endtask

  task automatic tick();
    model_edge();
    @(negedge clock);
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; i_in = 0; thr = 0; vr = 0;
    tick();
    check("reset.v_out", longint'(nif_a.v_out), 0);
    check("reset.count", longint'(nif_a.spike_count), 0);
    reset = 1'b0;

    // Leak of a positive potential: 1600 -> 1500 -> 1407
    en = 1'b1; i_in = 1600; thr = 32767; vr = 0;
    tick();
    check("leak.load", longint'(nif_a.v_out), 1600);
    i_in = 0;
    tick();
    check("leak.1", longint'(nif_a.v_out), 1500);
    tick();
    check("leak.2", longint'(nif_a.v_out), 1407);

    // Leak of a negative potential rounds toward minus infinity
    do_reset();
    i_in = -16;
    tick();
    i_in = 0;
    tick();
    check("leak.neg", longint'(nif_a.v_out), -15);

    // Constant supra-threshold drive: periods of 10 (a) and 2 (b)
    do_reset();
    en = 1'b1; i_in = 2000; thr = 1000; vr = 0;
    tick();
    check("fire.first", longint'(nif_a.spike), 1);
    repeat (29) tick();
    check("fire.count_a", longint'(nif_a.spike_count), 3);
    check("fire.count_b", longint'(nif_b.spike_count), 15);

    // Reset during the third refractory cycle
    do_reset();
    tick();
    repeat (3) tick();
    check("midref.refr", longint'(nif_a.refractory), 1);
    reset = 1'b1;
    tick();
    check("midref.refr_clr", longint'(nif_a.refractory), 0);
    check("midref.v_clr", longint'(nif_a.v_out), 0);
    check("midref.count_clr", longint'(nif_a.spike_count), 0);
    reset = 1'b0;
    tick();
    check("midref.resume", longint'(nif_a.spike), 1);

    // Enable low holds potential and ignores current
    do_reset();
    en = 1'b1; i_in = 300; thr = 100000; vr = 0;
    tick();
    tick();
    en = 1'b0; i_in = 5000;
    repeat (5) tick();
    check("hold.v", longint'(nif_a.v_out), 582);
    check("hold.spike", longint'(nif_a.spike), 0);

    // Positive and negative saturation
    do_reset();
    en = 1'b1; thr = 131071; vr = 131071; i_in = 131071;
    tick();
    check("sat.pos_v", longint'(nif_a.v_out), 131071);
    check("sat.pos_fire", longint'(nif_a.spike), 1);
    do_reset();
    en = 1'b1; thr = 131071; vr = 0; i_in = -131072;
    tick();
    tick();
    check("sat.neg_v", longint'(nif_a.v_out), -131072);

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      reset = ($urandom_range(0, 79) == 0);
      en    = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       i_in = rnd(-131072, 131071);
        1:       i_in = rnd(-400, 400);
        default: i_in = rnd(-500, 4000);
      endcase
      thr = ($urandom_range(0, 7) == 0) ? rnd(-131072, 131071) : rnd(-2000, 20000);
      vr  = ($urandom_range(0, 3) == 0) ? rnd(-131072, 131071) : rnd(-1000, 1000);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
